// File: rtl/digit_mux.sv
// digit_mux: time-multiplexes two hex digits onto one seven-segment decoder
// that drives a dual common-anode display. The anode enables are active-low.
// Optional feature macro MUX_BLANK_EN: when it is defined, blank windows are
// inserted between the digit windows (DIG0 -> BLANK0 -> DIG1 -> BLANK1).
// When it is undefined, the block alternates DIG0 <-> DIG1 directly.
//
// state  | meaning
// DIG0   | digit 0 lit (an0=0); s holds the s0 value latched on entry
// BLANK0 | both anodes off after digit 0; s holds
// DIG1   | digit 1 lit (an1=0); s holds the s1 value latched on entry
// BLANK1 | both anodes off after digit 1; s holds
module digit_mux #(
  parameter int HOLD_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [3:0] s,
  output logic       an0,
  output logic       an1,
  output logic       digit_sel
);

  localparam int MAXC = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
`ifdef MUX_BLANK_EN
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {DIG0, BLANK0, DIG1, BLANK1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          run, run_nxt;
  logic [3:0]    s_nxt;
  logic          an0_nxt, an1_nxt, sel_nxt;

  // Register the state, the counter and every output; reset forces the dark state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DIG0;
      count     <= '0;
      run       <= 1'b0;
      s         <= 4'h0;
      an0       <= 1'b1;
      an1       <= 1'b1;
      digit_sel <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      run       <= run_nxt;
      s         <= s_nxt;
      an0       <= an0_nxt;
      an1       <= an1_nxt;
      digit_sel <= sel_nxt;
    end
  end

  // Next-state logic: the down-counter expires at 0, and each DIG entry samples its digit.
  // The 'run' flag marks the first edge after reset as a fresh DIG0 entry.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    run_nxt   = 1'b1;
    s_nxt     = s;
    an0_nxt   = an0;
    an1_nxt   = an1;
    sel_nxt   = digit_sel;
    if (!run || (count == '0 && (state == BLANK1 || state == DIG1
`ifdef MUX_BLANK_EN
        && 1'b0
`endif
        ))) begin
      state_nxt = DIG0;
      count_nxt = HOLD_LD;
      s_nxt     = s0;
      an0_nxt   = 1'b0;
      an1_nxt   = 1'b1;
      sel_nxt   = 1'b0;
    end else if (count != '0) begin
      count_nxt = count - CW'(1);
    end else begin
      case (state)
`ifdef MUX_BLANK_EN
        DIG0: begin
          state_nxt = BLANK0;
          count_nxt = BLANK_LD;
          an0_nxt   = 1'b1;
          an1_nxt   = 1'b1;
        end
        DIG1: begin
          state_nxt = BLANK1;
          count_nxt = BLANK_LD;
          an0_nxt   = 1'b1;
          an1_nxt   = 1'b1;
        end
`endif
        BLANK1: begin
          state_nxt = DIG0;
          count_nxt = HOLD_LD;
          s_nxt     = s0;
          an0_nxt   = 1'b0;
          an1_nxt   = 1'b1;
          sel_nxt   = 1'b0;
        end
        default: begin
          state_nxt = DIG1;
          count_nxt = HOLD_LD;
          s_nxt     = s1;
          an0_nxt   = 1'b1;
          an1_nxt   = 1'b0;
          sel_nxt   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_mux.sv
module tb_digit_mux;

  localparam int HOLD  = 4;
  localparam int BLANK = 2;
`ifdef MUX_BLANK_EN
  localparam int D1_START = HOLD + BLANK;
`else
  localparam int D1_START = HOLD;
`endif
  localparam int PER = 2 * D1_START;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] s0 = 4'h0, s1 = 4'h0;
  logic [3:0] s;
  logic       an0, an1, digit_sel;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Reference model: the display timeline as a function of the edges since release.
  int         k = 0;
  logic [3:0] m_s = 4'h0;
  logic       m_an0 = 1'b1, m_an1 = 1'b1, m_sel = 1'b0;

  digit_mux #(.HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset), .s0(s0), .s1(s1),
    .s(s), .an0(an0), .an1(an1), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  // Anodes must never both be driven low.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (!an0 && !an1) begin
        miscompares++;
        $display("FAIL anode_overlap t=%0t an0=%b an1=%b required not both 0", $time, an0, an1);
      end
    end
  end

  // Advance the model by one edge using the inputs present now, then clock the DUT.
  task automatic step();
    int p;
    if (reset) begin
      k = 0; m_s = 4'h0; m_an0 = 1'b1; m_an1 = 1'b1; m_sel = 1'b0;
    end else begin
      p = k % PER;
      k++;
      if (p == 0) begin m_s = s0; m_sel = 1'b0; end
      else if (p == D1_START) begin m_s = s1; m_sel = 1'b1; end
      m_an0 = !(p < HOLD);
      m_an1 = !(p >= D1_START && p < D1_START + HOLD);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({s, an0, an1, digit_sel} !== 7'b0000_110) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got s=%h an0=%b an1=%b sel=%b required s=0 an0=1 an1=1 sel=0",
                 i, s, an0, an1, digit_sel);
      end
    end
  endtask

  task automatic test_sequence();
    s0 = 4'h3; s1 = 4'hA;
    reset = 1'b0;
    for (int i = 0; i < 3 * PER; i++) begin
      step();
      vectors++;
      if ({s, an0, an1, digit_sel} !== {m_s, m_an0, m_an1, m_sel}) begin
        miscompares++;
        $display("FAIL sequence cyc=%0d got s=%h an0=%b an1=%b sel=%b required s=%h an0=%b an1=%b sel=%b",
                 i, s, an0, an1, digit_sel, m_s, m_an0, m_an1, m_sel);
      end
    end
  endtask

  task automatic test_no_tearing();
    reset = 1'b1; step();
    reset = 1'b0; s0 = 4'h5;
    for (int i = 0; i < PER + 2; i++) begin
      step();
      if (i == 0) s0 = 4'h9;
      vectors++;
      if ({s, an0, an1, digit_sel} !== {m_s, m_an0, m_an1, m_sel}) begin
        miscompares++;
        $display("FAIL no_tearing cyc=%0d got s=%h an0=%b an1=%b sel=%b required s=%h an0=%b an1=%b sel=%b",
                 i, s, an0, an1, digit_sel, m_s, m_an0, m_an1, m_sel);
      end
    end
    vectors++;
    if (s !== 4'h9) begin
      miscompares++;
      $display("FAIL no_tearing_reentry got s=%h required s=9", s);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; step();
    reset = 1'b0; s0 = 4'h7; s1 = 4'hC;
    for (int i = 0; i < D1_START + 2; i++) step();
    reset = 1'b1;
    step();
    vectors++;
    if ({s, an0, an1, digit_sel} !== 7'b0000_110) begin
      miscompares++;
      $display("FAIL reset_mid got s=%h an0=%b an1=%b sel=%b required s=0 an0=1 an1=1 sel=0",
               s, an0, an1, digit_sel);
    end
    reset = 1'b0;
    for (int i = 0; i < HOLD + 2; i++) begin
      step();
      vectors++;
      if ({s, an0, an1, digit_sel} !== {m_s, m_an0, m_an1, m_sel}) begin
        miscompares++;
        $display("FAIL reset_mid_restart cyc=%0d got s=%h an0=%b an1=%b sel=%b required s=%h an0=%b an1=%b sel=%b",
                 i, s, an0, an1, digit_sel, m_s, m_an0, m_an1, m_sel);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      s0 = 4'($urandom);
      s1 = 4'($urandom);
      reset = ($urandom_range(0, 99) < 2);
      step();
      vectors++;
      if ({s, an0, an1, digit_sel} !== {m_s, m_an0, m_an1, m_sel}) begin
        miscompares++;
        $display("FAIL random cyc=%0d got s=%h an0=%b an1=%b sel=%b required s=%h an0=%b an1=%b sel=%b",
                 i, s, an0, an1, digit_sel, m_s, m_an0, m_an1, m_sel);
      end
    end
  endtask

  initial begin
    #2;
    mon_en = 1'b1;
    test_reset();
    test_sequence();
    test_no_tearing();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
